clock_rate_monitor: RTL

- Consumes a slow clock (e.g. a divided clock or an external square wave) as an ordinary signal sampled in the fast system clock domain.
- Synchronizes it and detects its rising and falling edges.
- Measures period and high time in fast-clock cycles.
- Reports lock when the rate is stable, and loss when edges stop.

---
 rtl/clock_rate_monitor.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/clock_rate_monitor.sv
// clock_rate_monitor
// Samples a slow clock in the fast clock domain, detects its edges, measures
// period and high time in fast-clock cycles, and reports lock when
// consecutive periods agree and loss when rising edges stop arriving.
module clock_rate_monitor #(
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 50000,
  parameter int TOLERANCE  = 2,
  parameter int LOCK_COUNT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sampleClock,
  output logic             risePulse,
  output logic             fallPulse,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] highTime,
  output logic             periodValid,
  output logic             locked,
  output logic             lost
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W:0]   TOL     = (CNT_W+1)'(TOLERANCE);
  localparam logic [3:0]       LOCK_N  = 4'(LOCK_COUNT);

  state_t state;
  state_t stateNext;

  logic             s1;
  logic             s2;
  logic             s3;
  logic             rise;
  logic             fall;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cntPlus;
  logic [CNT_W-1:0] cntNext;
  logic [CNT_W-1:0] prevPeriod;
  logic [CNT_W-1:0] prevNext;
  logic [CNT_W-1:0] periodNext;
  logic [CNT_W-1:0] highNext;
  logic [3:0]       matchCount;
  logic [3:0]       matchInc;
  logic [3:0]       mcNext;
  logic             havePrev;
  logic             havePrevNext;

  logic [CNT_W:0]   diff;
  logic [CNT_W:0]   absDiff;
  logic             match;
  logic             tracking;
  logic             timeout;
  logic             lockHit;
  logic             publish;
  logic             entry;

  logic             pvNext;
  logic             lockedNext;
  logic             lostNext;

  // Edge detection on the synchronised slow clock
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  // Measurement arithmetic shared by the FSM and the output decode
  always_comb begin
    cntPlus  = cnt + CNT_W'(1);
    diff     = {1'b0, cntPlus} - {1'b0, prevPeriod};
    absDiff  = diff[CNT_W] ? ((CNT_W+1)'(0) - diff) : diff;
    match    = (absDiff <= TOL);
    tracking = (state == ACQUIRE) || (state == LOCKED);
    // A rise on the saturation cycle is a legal edge, so it masks the timeout
    timeout  = tracking && !rise && (cnt == CNT_MAX);
    publish  = tracking && rise;
    entry    = rise && ((state == SEARCH) || (state == LOST));
    matchInc = (matchCount == 4'hF) ? matchCount : matchCount + 4'd1;
    if (!havePrev) begin
      mcNext = '0;
    end else if (match) begin
      mcNext = matchInc;
    end else begin
      mcNext = '0;
    end
    lockHit  = havePrev && (mcNext == LOCK_N);
  end

  // State register
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= SEARCH;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state decode; rise always wins over a coincident timeout
  always_comb begin
    stateNext = state;
    unique case (state)
      SEARCH: begin
        if (rise) stateNext = ACQUIRE;
      end
      ACQUIRE: begin
        if (rise) begin
          if (lockHit) stateNext = LOCKED;
        end else if (timeout) begin
          stateNext = LOST;
        end
      end
      LOCKED: begin
        if (rise) begin
          if (!match) stateNext = ACQUIRE;
        end else if (timeout) begin
          stateNext = LOST;
        end
      end
      LOST: begin
        if (rise) stateNext = ACQUIRE;
      end
      default: stateNext = SEARCH;
    endcase
  end

  // Output and datapath next-value decode
  always_comb begin
    cntNext      = rise ? '0 : ((cnt == CNT_MAX) ? cnt : cntPlus);
    periodNext   = publish ? cntPlus : period;
    prevNext     = publish ? cntPlus : prevPeriod;
    pvNext       = publish;
    highNext     = (tracking && fall) ? cntPlus : highTime;
    // Entry from SEARCH/LOST discards history: the first interval is unreferenced
    havePrevNext = havePrev;
    mcNext_sel: begin end
    if (entry) begin
      havePrevNext = 1'b0;
    end else if (publish) begin
      havePrevNext = 1'b1;
    end
    lockedNext   = (stateNext == LOCKED);
    lostNext     = lost;
    if (stateNext == LOST) begin
      lostNext = 1'b1;
    end else if (stateNext == LOCKED) begin
      lostNext = 1'b0;
    end
  end

  // Synchroniser, counter, measurement and registered outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      s3          <= 1'b0;
      cnt         <= '0;
      matchCount  <= '0;
      prevPeriod  <= '0;
      havePrev    <= 1'b0;
      risePulse   <= 1'b0;
      fallPulse   <= 1'b0;
      period      <= '0;
      highTime    <= '0;
      periodValid <= 1'b0;
      locked      <= 1'b0;
      lost        <= 1'b0;
    end else begin
      s1          <= sampleClock;
      s2          <= s1;
      s3          <= s2;
      cnt         <= cntNext;
      if (entry) begin
        matchCount <= '0;
      end else if (publish) begin
        matchCount <= mcNext;
      end
      prevPeriod  <= prevNext;
      havePrev    <= havePrevNext;
      risePulse   <= rise;
      fallPulse   <= fall;
      period      <= periodNext;
      highTime    <= highNext;
      periodValid <= pvNext;
      locked      <= lockedNext;
      lost        <= lostNext;
    end
  end

endmodule
